// File: rtl/branch_ctrl.sv
// Branch redirect/flush controller: one REDIRECT cycle, then FLUSH until FLUSH_CYCLES squash cycles are done.
// Optional taken-branch statistics counter is enabled by defining BRANCH_STATS_EN.
module branch_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_cntrl,
  input  logic        in_comp,
  input  logic        in_stall,
`ifdef BRANCH_STATS_EN
  input  logic        in_clr_stats,
  output logic [15:0] out_taken_cnt,
`endif
  output logic        out_pc_sel,
  output logic        out_flush,
  output logic        out_busy,
  output logic [1:0]  out_state
);

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] REDIRECT = 2'b01;
  localparam logic [1:0] FLUSH    = 2'b10;

  logic [1:0] state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       take;

  // Branch requests only count when idle and unstalled; later slots are squashed.
  assign take = (state == IDLE) && in_cntrl && in_comp && !in_stall;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (take) state_nxt = REDIRECT;
      end
      REDIRECT: begin
        if (!in_stall) begin
          if (FLUSH_CYCLES == 1) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = FLUSH;
            cnt_nxt   = 3'(FLUSH_CYCLES - 1);
          end
        end
      end
      FLUSH: begin
        if (!in_stall) begin
          if (cnt <= 3'd1) begin
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      out_pc_sel <= 1'b0;
      out_flush  <= 1'b0;
      out_busy   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      out_pc_sel <= (state_nxt == REDIRECT);
      out_flush  <= (state_nxt == REDIRECT) || (state_nxt == FLUSH);
      out_busy   <= (state_nxt == REDIRECT) || (state_nxt == FLUSH);
    end
  end

  assign out_state = state;

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 out_taken_cnt <= 16'd0;
    else if (in_clr_stats)                     out_taken_cnt <= 16'd0;
    else if (take && out_taken_cnt != 16'hFFFF) out_taken_cnt <= out_taken_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles out_flush is asserted per taken branch; legal range 1..7.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_cntrl  input  1  branch control from decode: current instruction is a branch.
REQ-005 in_comp  input  1  comparator result: branch condition true.
REQ-006 in_stall  input  1  pipeline stall from hazard logic; freezes the controller.
REQ-007 out_pc_sel  output  1  PC source select: 1 = branch target, 0 = PC+4.
REQ-008 out_flush  output  1  squash IF/ID contents (insert bubble).
REQ-009 out_busy  output  1  controller is not IDLE; new branch requests are ignored.
REQ-010 out_state  output  2  current FSM state encoding (IDLE=00, REDIRECT=01, FLUSH=10).
REQ-011 in_clr_stats  input  1  synchronous clear of the taken counter (present only with BRANCH_STATS_EN).
REQ-012 out_taken_cnt  output  16  count of taken branches (present only with BRANCH_STATS_EN).

Function
REQ-013 Taken condition SHALL be in_cntrl AND in_comp, evaluated only in IDLE with in_stall=0.
REQ-014 IDLE: taken at edge N -> REDIRECT after edge N; otherwise remain in IDLE.
REQ-015 REDIRECT: out_pc_sel=1, out_flush=1, out_busy=1; registered outputs, 1-cycle latency from the sampling edge.
REQ-016 REDIRECT with in_stall=0: FLUSH_CYCLES=1 -> IDLE; otherwise -> FLUSH and load the flush counter with FLUSH_CYCLES-1.
REQ-017 FLUSH: out_pc_sel=0, out_flush=1, out_busy=1; counter decrements each unstalled cycle; counter reaching 1 with in_stall=0 -> IDLE.
REQ-018 Total out_flush high time per taken branch SHALL be exactly FLUSH_CYCLES unstalled cycles; out_pc_sel high for exactly 1 unstalled cycle.
REQ-019 in_stall=1 in REDIRECT or FLUSH SHALL hold state, counter and all outputs unchanged.
REQ-020 in_stall=1 in IDLE SHALL suppress the taken condition even when in_cntrl=in_comp=1.
REQ-021 in_cntrl/in_comp SHALL be ignored in REDIRECT and FLUSH; those instructions are in squashed slots.
REQ-022 Back-to-back: a taken condition in the first IDLE cycle after FLUSH SHALL be accepted normally (no dead cycle).
REQ-023 In IDLE, out_pc_sel=0, out_flush=0 and out_busy=0.
REQ-024 Unused state encoding 11 SHALL recover to IDLE on the next edge with all outputs 0.

Reset
REQ-025 reset=1 SHALL immediately force IDLE, counter 0, out_pc_sel=0, out_flush=0, out_busy=0, out_state=00 and out_taken_cnt=0, independent of clk.
REQ-026 reset asserted mid-REDIRECT/FLUSH SHALL abort the sequence; after release the first edge evaluates from IDLE.

Configuration
REQ-027 Macro BRANCH_STATS_EN defined: in_clr_stats and out_taken_cnt SHALL exist.
REQ-028 With the macro defined, out_taken_cnt SHALL increment on each IDLE->REDIRECT transition and saturate at 16'hFFFF.
REQ-029 With the macro defined, in_clr_stats=1 SHALL zero out_taken_cnt at the edge and take priority over a simultaneous increment.
REQ-030 Macro undefined: neither port nor counter logic exists; all other behaviour is identical.

Verification
REQ-031 Truth sweep in IDLE: (cntrl,comp) = 00,01,10 -> no transition; 11 -> out_pc_sel=1, out_flush=1 on the next cycle.
REQ-032 FLUSH_CYCLES=2, taken at edge 0 -> out_pc_sel 1 for cycle 1 only, out_flush 1 for cycles 1-2, out_busy back to 0 at cycle 3.
REQ-033 Stall 3 cycles during FLUSH -> state, outputs and counter frozen; out_flush total = FLUSH_CYCLES + 3 cycles.
REQ-034 in_cntrl=in_comp=1 held continuously, FLUSH_CYCLES=2 -> REDIRECT every 3rd cycle; requests in REDIRECT/FLUSH ignored.
REQ-035 reset pulse mid-FLUSH between clock edges -> outputs 0 immediately; IDLE after release.
REQ-036 BRANCH_STATS_EN: 5 taken branches -> out_taken_cnt=5; clr coincident with a take -> 0; preload 16'hFFFF plus a take -> 16'hFFFF.
